// File: rtl/bta_operand_scheduler.sv
// Operand scheduler for a fixed-latency tree adder: collects up to NOPS operands
// per job, launches the adder once, and holds the sum until it is consumed.
// Optional BTA_SCHED_JOBCNT_EN adds a saturating completed-job counter (job_cnt).
module bta_operand_scheduler #(
  parameter int unsigned W    = 16,
  parameter int unsigned NOPS = 8,
  parameter int unsigned LAT  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  input  logic                         in_last,
  output logic [NOPS*W-1:0]            add_ops,
  output logic                         add_go,
  input  logic [W+$clog2(NOPS)-1:0]    add_sum,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W+$clog2(NOPS)-1:0]    out_sum,
  output logic [$clog2(NOPS):0]        out_count
`ifdef BTA_SCHED_JOBCNT_EN
  ,
  output logic [15:0]                  job_cnt
`endif
);

  localparam int unsigned SW = W + $clog2(NOPS);
  localparam int unsigned CW = $clog2(NOPS) + 1;
  localparam int unsigned LW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LAUNCH  = 2'd1,
    WAIT    = 2'd2,
    OUTPUT  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CW-1:0]       r_idx;
  logic [LW-1:0]       r_lat;
  logic [NOPS*W-1:0]   r_bank;
  logic [SW-1:0]       r_out_sum;
  logic [CW-1:0]       r_out_count;
  logic                r_add_go;
  logic                r_in_ready;
  logic                r_out_valid;

  logic                w_xfer;
  logic                w_close;
  logic                w_lat_done;
  logic                w_out_hs;

  assign w_xfer     = in_valid && (r_state == COLLECT);
  assign w_close    = w_xfer && (in_last || (r_idx == CW'(NOPS - 1)));
  assign w_lat_done = (r_state == WAIT) && (r_lat == LW'(1));
  assign w_out_hs   = (r_state == OUTPUT) && out_ready;

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      COLLECT: if (w_close)    w_state_next = LAUNCH;
      LAUNCH:                  w_state_next = WAIT;
      WAIT:    if (w_lat_done) w_state_next = OUTPUT;
      OUTPUT:  if (w_out_hs)   w_state_next = COLLECT;
      default:                 w_state_next = COLLECT;
    endcase
  end

  // State register and registered handshake/strobe outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= COLLECT;
      r_add_go    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_add_go    <= (w_state_next == LAUNCH);
      r_in_ready  <= (w_state_next == COLLECT);
      r_out_valid <= (w_state_next == OUTPUT);
    end
  end

  // Operand bank, index, latency counter and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank      <= '0;
      r_idx       <= '0;
      r_lat       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
    end else begin
      if (w_xfer) begin
        r_idx <= r_idx + CW'(1);
        for (int unsigned k = 0; k < NOPS; k++) begin
          if (r_idx == CW'(k)) r_bank[k*W +: W] <= in_data;
        end
      end
      if (r_state == LAUNCH) begin
        r_lat <= LW'(LAT);
      end else if (r_state == WAIT) begin
        r_lat <= r_lat - LW'(1);
      end
      if (w_lat_done) begin
        r_out_sum   <= add_sum;
        r_out_count <= r_idx;
      end
      // Clearing on consume leaves the bank zeroed for the next job's unused slots
      if (w_out_hs) begin
        r_bank <= '0;
        r_idx  <= '0;
      end
    end
  end

`ifdef BTA_SCHED_JOBCNT_EN
  logic [15:0] r_job_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_job_cnt <= '0;
    end else if (w_out_hs && (r_job_cnt != 16'hFFFF)) begin
      r_job_cnt <= r_job_cnt + 16'd1;
    end
  end

  assign job_cnt = r_job_cnt;
`endif

  assign in_ready  = r_in_ready;
  assign add_ops   = r_bank;
  assign add_go    = r_add_go;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_bta_operand_scheduler.sv
// Self-checking bench for bta_operand_scheduler with an ideal LAT-cycle tree adder.
module tb_bta_operand_scheduler;

  localparam int unsigned W    = 16;
  localparam int unsigned NOPS = 8;
  localparam int unsigned LAT  = 2;
  localparam int unsigned SW   = W + $clog2(NOPS);
  localparam int unsigned CW   = $clog2(NOPS) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_data = '0;
  logic                in_last = 1'b0;
  logic [NOPS*W-1:0]   add_ops;
  logic                add_go;
  logic [SW-1:0]       add_sum;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [SW-1:0]       out_sum;
  logic [CW-1:0]       out_count;
`ifdef BTA_SCHED_JOBCNT_EN
  logic [15:0]         job_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bta_operand_scheduler #(.W(W), .NOPS(NOPS), .LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_ops   (add_ops),
    .add_go    (add_go),
    .add_sum   (add_sum),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
`ifdef BTA_SCHED_JOBCNT_EN
    ,
    .job_cnt   (job_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Ideal tree adder: sum of the bank sampled on add_go, valid LAT cycles later; junk otherwise
  function automatic logic [SW-1:0] tree_sum(input logic [NOPS*W-1:0] b);
    logic [SW-1:0] s;
    s = '0;
    for (int k = 0; k < NOPS; k++) s = s + SW'(b[k*W +: W]);
    return s;
  endfunction

  logic [SW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= add_go ? tree_sum(add_ops) : SW'($urandom);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign add_sum = pipe[LAT-1];

  // Reference: expected sum and bank image from an operand list
  function automatic logic [SW-1:0] ref_sum(input logic [W-1:0] v [NOPS], input int n);
    longint s;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(v[i]);
    return SW'(s);
  endfunction

  function automatic logic [NOPS*W-1:0] ref_bank(input logic [W-1:0] v [NOPS], input int n);
    logic [NOPS*W-1:0] b;
    b = '0;
    for (int i = 0; i < n; i++) b[i*W +: W] = v[i];
    return b;
  endfunction

  // Drives one job; reports timing/stability observations up to the first out_valid
  task automatic send_job(input logic [W-1:0] vals [NOPS], input int n, input bit use_last,
                          input int gap_max, output int lat_edges, output bit ready_low,
                          output bit ops_stable, output logic [NOPS*W-1:0] ops_seen,
                          output int go_cycles);
    int budget;
    lat_edges = -1; ready_low = 1'b0; ops_stable = 1'b0; ops_seen = '0; go_cycles = 0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < $urandom_range(gap_max, 0); g++) begin
        in_valid = 1'b0; in_last = 1'($urandom); in_data = W'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = vals[i]; in_last = use_last && (i == n - 1);
      budget = 0;
      while (!in_ready && budget < 50) begin @(posedge clk); #1; budget++; end
      if (budget >= 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
        in_valid = 1'b0; in_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    ready_low = !in_ready; go_cycles = int'(add_go); ops_seen = add_ops; ops_stable = 1'b1;
    lat_edges = 0;
    while (!out_valid && lat_edges < 50) begin
      @(posedge clk); #1; lat_edges++;
      if (in_ready) ready_low = 1'b0;
      if (!out_valid) begin
        go_cycles += int'(add_go);
        if (add_ops !== ops_seen) ops_stable = 1'b0;
      end
    end
  endtask

  // Holds out_ready low for 'hold' cycles, then handshakes
  task automatic take_output(input int hold, output bit stable, output bit ready_low,
                             output logic [SW-1:0] sum, output logic [CW-1:0] cnt,
                             output bit ready_after);
    sum = out_sum; cnt = out_count; stable = out_valid; ready_low = !in_ready; out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!out_valid || out_sum !== sum || out_count !== cnt) stable = 1'b0;
      if (in_ready) ready_low = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ready_after = in_ready && !out_valid;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (add_go !== 1'b0) begin errors++; $display("FAIL reset_add_go: got %0b want 0", add_go); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (add_ops !== '0) begin errors++; $display("FAIL reset_add_ops: got %h want 0", add_ops); end
    checks++; if (out_sum !== '0 || out_count !== '0) begin errors++; $display("FAIL reset_out: sum %h cnt %0d want 0 0", out_sum, out_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_full_job();
    logic [W-1:0] v [NOPS];
    int lat, gos; bit rl, st, st2, rl2, ra; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < NOPS; i++) v[i] = 16'hFFFF;
    send_job(v, 8, 1'b1, 0, lat, rl, st, ops, gos);
    checks++; if (lat != int'(LAT) + 1) begin errors++; $display("FAIL full_latency: out_valid after %0d edges want %0d", lat, LAT + 1); end
    checks++; if (gos != 1) begin errors++; $display("FAIL full_add_go: high %0d cycles want 1", gos); end
    checks++; if (!rl) begin errors++; $display("FAIL full_in_ready: in_ready rose during job, want 0"); end
    take_output(0, st2, rl2, s, c, ra);
    checks++; if (s !== SW'(19'h7FFF8) || s !== ref_sum(v, 8)) begin errors++; $display("FAIL full_sum: got %h want 7fff8", s); end
    checks++; if (c !== CW'(8)) begin errors++; $display("FAIL full_count: got %0d want 8", c); end
  endtask

  task automatic test_short_job();
    logic [W-1:0] v [NOPS];
    int lat, gos; bit rl, st, st2, rl2, ra; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < NOPS; i++) v[i] = W'(i + 1);
    send_job(v, 3, 1'b1, 1, lat, rl, st, ops, gos);
    checks++; if (ops !== ref_bank(v, 3)) begin errors++; $display("FAIL short_bank: got %h want %h", ops, ref_bank(v, 3)); end
    checks++; if (!st) begin errors++; $display("FAIL short_stable: add_ops changed during WAIT, want stable"); end
    take_output(0, st2, rl2, s, c, ra);
    checks++; if (s !== SW'(6)) begin errors++; $display("FAIL short_sum: got %h want 6", s); end
    checks++; if (c !== CW'(3)) begin errors++; $display("FAIL short_count: got %0d want 3", c); end
  endtask

  task automatic test_implicit_last();
    logic [W-1:0] v [NOPS];
    int lat, gos; bit rl, st, st2, rl2, ra; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < NOPS; i++) v[i] = 16'h0001;
    send_job(v, 8, 1'b0, 0, lat, rl, st, ops, gos);
    checks++; if (!rl) begin errors++; $display("FAIL implicit_in_ready: in_ready high after 8th, want 0"); end
    checks++; if (lat != int'(LAT) + 1) begin errors++; $display("FAIL implicit_latency: %0d edges want %0d", lat, LAT + 1); end
    take_output(0, st2, rl2, s, c, ra);
    checks++; if (s !== SW'(8) || c !== CW'(8)) begin errors++; $display("FAIL implicit_result: sum %h cnt %0d want 8 8", s, c); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] v [NOPS];
    int lat, gos, n; bit rl, st, st2, rl2, ra; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    n = $urandom_range(NOPS, 1);
    for (int i = 0; i < NOPS; i++) v[i] = W'($urandom);
    send_job(v, n, 1'b1, 0, lat, rl, st, ops, gos);
    take_output(5, st2, rl2, s, c, ra);
    checks++; if (!st2) begin errors++; $display("FAIL bp_stable: out_valid/out_sum moved while stalled, want stable"); end
    checks++; if (!rl2) begin errors++; $display("FAIL bp_in_ready: in_ready rose while stalled, want 0"); end
    checks++; if (!ra) begin errors++; $display("FAIL bp_after: in_ready=%0b out_valid=%0b after handshake, want 1 0", in_ready, out_valid); end
    checks++; if (s !== ref_sum(v, n)) begin errors++; $display("FAIL bp_sum: got %h want %h", s, ref_sum(v, n)); end
  endtask

  task automatic test_reset_mid_wait();
    logic [W-1:0] v [NOPS];
    int lat, gos; bit rl, st, st2, rl2, ra, seen; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = W'($urandom); in_last = (i == 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (add_ops !== '0 || add_go !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: ops %h go %0b ov %0b want 0 0 0", add_ops, add_go, out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_no_output: out_valid asserted for discarded job, want never"); end
    v[0] = 16'h1234;
    for (int i = 1; i < NOPS; i++) v[i] = '0;
    send_job(v, 1, 1'b1, 0, lat, rl, st, ops, gos);
    take_output(0, st2, rl2, s, c, ra);
    checks++; if (s !== SW'(16'h1234) || c !== CW'(1)) begin errors++; $display("FAIL rstmid_next: sum %h cnt %0d want 1234 1", s, c); end
  endtask

  task automatic test_random();
    logic [W-1:0] v [NOPS];
    int lat, gos, n; bit rl, st, st2, rl2, ra, ul; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    for (int j = 0; j < 24; j++) begin
      n = $urandom_range(NOPS, 1);
      ul = (n == int'(NOPS)) ? 1'($urandom) : 1'b1;
      for (int i = 0; i < NOPS; i++) v[i] = W'($urandom);
      send_job(v, n, ul, 2, lat, rl, st, ops, gos);
      checks++; if (lat != int'(LAT) + 1 || gos != 1) begin errors++; $display("FAIL rand_timing job %0d: lat %0d go %0d want %0d 1", j, lat, gos, LAT + 1); end
      checks++; if (ops !== ref_bank(v, n) || !st) begin errors++; $display("FAIL rand_bank job %0d: got %h want %h stable %0b", j, ops, ref_bank(v, n), st); end
      take_output($urandom_range(3, 0), st2, rl2, s, c, ra);
      checks++; if (s !== ref_sum(v, n) || c !== CW'(n)) begin errors++; $display("FAIL rand_result job %0d: sum %h cnt %0d want %h %0d", j, s, c, ref_sum(v, n), n); end
      checks++; if (!st2 || !rl2 || !ra) begin errors++; $display("FAIL rand_handshake job %0d: stable %0b ready_low %0b ready_after %0b want 1 1 1", j, st2, rl2, ra); end
    end
  endtask

`ifdef BTA_SCHED_JOBCNT_EN
  task automatic test_job_cnt();
    logic [W-1:0] v [NOPS];
    int lat, gos; bit rl, st, st2, rl2, ra; logic [NOPS*W-1:0] ops; logic [SW-1:0] s; logic [CW-1:0] c;
    do_reset();
    for (int i = 0; i < NOPS; i++) v[i] = W'(i);
    for (int j = 0; j < 3; j++) begin
      send_job(v, 2, 1'b1, 0, lat, rl, st, ops, gos);
      take_output(1, st2, rl2, s, c, ra);
    end
    checks++; if (job_cnt !== 16'd3) begin errors++; $display("FAIL job_cnt: got %0d want 3", job_cnt); end
    rst = 1'b1; #1;
    checks++; if (job_cnt !== 16'd0) begin errors++; $display("FAIL job_cnt_reset: got %0d want 0", job_cnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_job();
    test_short_job();
    test_implicit_last();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
`ifdef BTA_SCHED_JOBCNT_EN
    test_job_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
